// File: rtl/tor_network_emu_pkg.sv
// ============================================================================
// Module  : tor_network_emu_pkg
// Purpose : Shared types and width constants for the emulated top-of-rack
//           network (packet type, lane entry layout, default widths).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tor_network_emu_pkg;

  // Transport payload carried between the two NICs.
  localparam int TRANSPORT_DATA_WIDTH = 64;

  typedef struct packed {
    logic [TRANSPORT_DATA_WIDTH-1:0] payload;
  } NetworkPacketInternal;

  // Default geometry of one delay lane.
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LAT_W = 10;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 32;

  // Lane entry at the default widths. The lane builds the same layout from
  // its own parameters so non-default instances stay consistent.
  typedef struct packed {
    NetworkPacketInternal  data;
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_LAT_W-1:0]  lat;
  } lane_entry_t;

endpackage

`default_nettype wire

// File: rtl/tor_delay_lane.sv
// ============================================================================
// Module  : tor_delay_lane
// Purpose : One direction of the emulated network. Buffers up to DEPTH
//           packets, releases each one a programmable number of cycles after
//           it was accepted (strict FIFO order), drops on full and counts drops.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           now_i             - shared free-running timestamp
//           cfg_latency_i     - target latency, sampled at enqueue
//           tx_i / tx_valid_i - incoming packet and strobe
//           rx_o / rx_valid_o - registered outgoing packet and 1-cycle strobe
//           drop_cnt_o        - saturating drop counter
//           occupancy_o       - current fill level
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tor_delay_lane
  import tor_network_emu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LAT_W = 10,
  parameter int TS_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TS_W-1:0]          now_i,
  input  logic [LAT_W-1:0]         cfg_latency_i,
  input  NetworkPacketInternal     tx_i,
  input  logic                     tx_valid_i,
  output NetworkPacketInternal     rx_o,
  output logic                     rx_valid_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    NetworkPacketInternal data;
    logic [TS_W-1:0]      ts;
    logic [LAT_W-1:0]     lat;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W:0]       occ_q;
  logic [PTR_W:0]       occ_d;
  NetworkPacketInternal rx_q;
  logic                 rx_valid_q;
  logic [CNT_W-1:0]     drop_q;

  logic                 full;
  logic                 empty;
  logic                 enq;
  logic                 drop;
  logic                 rel;
  logic [LAT_W-1:0]     lat_eff;
  logic [TS_W-1:0]      age;
  logic [TS_W-1:0]      lat_ext;
  entry_t               head;

  // Full is judged on the level before this cycle's release, so an arrival
  // that coincides with a release from a full lane is still dropped.
  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == '0);
  assign enq     = tx_valid_i && !full;
  assign drop    = tx_valid_i && full;
  assign lat_eff = (cfg_latency_i == '0) ? LAT_W'(1) : cfg_latency_i;

  // ts holds the counter value of the cycle the packet was accepted in, so
  // an age of lat means lat edges have passed since the enqueue edge. The
  // modular subtraction stays correct across a counter wrap because residence
  // time is far below half the counter range.
  assign head    = mem_q[rd_ptr_q];
  assign age     = now_i - head.ts;
  assign lat_ext = TS_W'(head.lat);
  assign rel     = !empty && (age >= lat_ext);

  always_comb begin
    occ_d = occ_q;
    case ({enq, rel})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is not reset; pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= '{data: tx_i, ts: now_i, lat: lat_eff};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      rx_valid_q <= rel;
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rel) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        rx_q     <= head.data;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign rx_o        = rx_q;
  assign rx_valid_o  = rx_valid_q;
  assign drop_cnt_o  = drop_q;
  assign occupancy_o = occ_q;

endmodule

`default_nettype wire

// File: rtl/tor_network_emu.sv
// ============================================================================
// Module  : tor_network_emu
// Purpose : Emulated top-of-rack network between two NICs: two independent
//           programmable-latency delay lanes (NIC_0 TX -> NIC_1 RX and
//           NIC_1 TX -> NIC_0 RX) sharing one timestamp counter.
// Ports   : clk, reset                      - network clock, sync reset
//           cfg_latency                     - one-way latency for both lanes
//           nic0_tx_in/_valid_in            - NIC_0 transmit
//           nic1_tx_in/_valid_in            - NIC_1 transmit
//           nic0_rx_out/_valid_out          - delivery to NIC_0
//           nic1_rx_out/_valid_out          - delivery to NIC_1
//           drop_cnt_0to1/_1to0             - saturating drop counters
//           occupancy_0to1/_1to0            - lane fill levels
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tor_network_emu
  import tor_network_emu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LAT_W = 10,
  parameter int TS_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LAT_W-1:0]         cfg_latency,
  input  NetworkPacketInternal     nic0_tx_in,
  input  logic                     nic0_tx_valid_in,
  input  NetworkPacketInternal     nic1_tx_in,
  input  logic                     nic1_tx_valid_in,
  output NetworkPacketInternal     nic0_rx_out,
  output logic                     nic0_rx_valid_out,
  output NetworkPacketInternal     nic1_rx_out,
  output logic                     nic1_rx_valid_out,
  output logic [CNT_W-1:0]         drop_cnt_0to1,
  output logic [CNT_W-1:0]         drop_cnt_1to0,
  output logic [$clog2(DEPTH):0]   occupancy_0to1,
  output logic [$clog2(DEPTH):0]   occupancy_1to0
);

  logic [TS_W-1:0] now_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      now_q <= '0;
    end else begin
      now_q <= now_q + TS_W'(1);
    end
  end

  tor_delay_lane #(
    .DEPTH (DEPTH),
    .LAT_W (LAT_W),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) u_lane_0to1 (
    .clk           (clk),
    .reset         (reset),
    .now_i         (now_q),
    .cfg_latency_i (cfg_latency),
    .tx_i          (nic0_tx_in),
    .tx_valid_i    (nic0_tx_valid_in),
    .rx_o          (nic1_rx_out),
    .rx_valid_o    (nic1_rx_valid_out),
    .drop_cnt_o    (drop_cnt_0to1),
    .occupancy_o   (occupancy_0to1)
  );

  tor_delay_lane #(
    .DEPTH (DEPTH),
    .LAT_W (LAT_W),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) u_lane_1to0 (
    .clk           (clk),
    .reset         (reset),
    .now_i         (now_q),
    .cfg_latency_i (cfg_latency),
    .tx_i          (nic1_tx_in),
    .tx_valid_i    (nic1_tx_valid_in),
    .rx_o          (nic0_rx_out),
    .rx_valid_o    (nic0_rx_valid_out),
    .drop_cnt_o    (drop_cnt_1to0),
    .occupancy_o   (occupancy_1to0)
  );

endmodule

`default_nettype wire

// File: tb/tb_tor_network_emu.sv
// ============================================================================
// Module  : tb_tor_network_emu
// Purpose : Self-checking bench for tor_network_emu. A queue-based model
//           (per-packet due time = enqueue edge + latency) is compared with
//           the DUT after every clock edge; directed sequences cover the
//           latency table, bursts, overflow, latency decrease, mid-flight
//           reset and timestamp wrap, followed by random traffic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tor_network_emu;
  import tor_network_emu_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT_W = 8;
  localparam int TS_W  = 13;
  localparam int CNT_W = 6;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [LAT_W-1:0]     cfg_latency;
  NetworkPacketInternal nic0_tx_in;
  NetworkPacketInternal nic1_tx_in;
  logic                 nic0_tx_valid_in;
  logic                 nic1_tx_valid_in;
  NetworkPacketInternal nic0_rx_out;
  NetworkPacketInternal nic1_rx_out;
  logic                 nic0_rx_valid_out;
  logic                 nic1_rx_valid_out;
  logic [CNT_W-1:0]     drop_cnt_0to1;
  logic [CNT_W-1:0]     drop_cnt_1to0;
  logic [OCC_W-1:0]     occupancy_0to1;
  logic [OCC_W-1:0]     occupancy_1to0;

  always #5 clk = ~clk;

  tor_network_emu #(
    .DEPTH (DEPTH),
    .LAT_W (LAT_W),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_latency       (cfg_latency),
    .nic0_tx_in        (nic0_tx_in),
    .nic0_tx_valid_in  (nic0_tx_valid_in),
    .nic1_tx_in        (nic1_tx_in),
    .nic1_tx_valid_in  (nic1_tx_valid_in),
    .nic0_rx_out       (nic0_rx_out),
    .nic0_rx_valid_out (nic0_rx_valid_out),
    .nic1_rx_out       (nic1_rx_out),
    .nic1_rx_valid_out (nic1_rx_valid_out),
    .drop_cnt_0to1     (drop_cnt_0to1),
    .drop_cnt_1to0     (drop_cnt_1to0),
    .occupancy_0to1    (occupancy_0to1),
    .occupancy_1to0    (occupancy_1to0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lane 0 = NIC_0 -> NIC_1, lane 1 = NIC_1 -> NIC_0.
  typedef struct {
    logic [63:0] data;
    int          due;
  } mrec_t;

  mrec_t       mq [2][$];
  logic [63:0] m_rx [2];
  logic        m_vld [2];
  int          m_drop [2];
  int          edge_n = 0;

  // One clock edge: sample inputs, advance the model, compare after #1.
  task automatic tick();
    logic        r;
    logic        v [2];
    logic [63:0] d [2];
    int          lat;
    int          occ_before;
    mrec_t       rec;
    r    = reset;
    v[0] = nic0_tx_valid_in;
    v[1] = nic1_tx_valid_in;
    d[0] = nic0_tx_in;
    d[1] = nic1_tx_in;
    lat  = (cfg_latency == '0) ? 1 : int'(cfg_latency);
    @(posedge clk);
    for (int l = 0; l < 2; l++) begin
      if (r) begin
        mq[l].delete();
        m_rx[l]   = '0;
        m_vld[l]  = 1'b0;
        m_drop[l] = 0;
      end else begin
        occ_before = mq[l].size();
        m_vld[l]   = 1'b0;
        if ((mq[l].size() > 0) && (mq[l][0].due <= edge_n)) begin
          m_rx[l]  = mq[l][0].data;
          m_vld[l] = 1'b1;
          void'(mq[l].pop_front());
        end
        if (v[l]) begin
          if (occ_before < DEPTH) begin
            rec.data = d[l];
            rec.due  = edge_n + lat;
            mq[l].push_back(rec);
          end else if (m_drop[l] < DROP_MAX) begin
            m_drop[l]++;
          end
        end
      end
    end
    edge_n++;
    #1;
    chk("rx1_valid", 64'(nic1_rx_valid_out), 64'(m_vld[0]));
    chk("rx1_data",  64'(nic1_rx_out),       m_rx[0]);
    chk("rx0_valid", 64'(nic0_rx_valid_out), 64'(m_vld[1]));
    chk("rx0_data",  64'(nic0_rx_out),       m_rx[1]);
    chk("occ_0to1",  64'(occupancy_0to1),    64'(mq[0].size()));
    chk("occ_1to0",  64'(occupancy_1to0),    64'(mq[1].size()));
    chk("drop_0to1", 64'(drop_cnt_0to1),     64'(m_drop[0]));
    chk("drop_1to0", 64'(drop_cnt_1to0),     64'(m_drop[1]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int lane, input logic [63:0] data);
    if (lane == 0) begin
      nic0_tx_in = data; nic0_tx_valid_in = 1'b1;
    end else begin
      nic1_tx_in = data; nic1_tx_valid_in = 1'b1;
    end
    tick();
    nic0_tx_valid_in = 1'b0;
    nic1_tx_valid_in = 1'b0;
  endtask

  // Ticks until the destination of 'lane' strobes; dly = -1 if the budget expires.
  task automatic wait_rx(input int lane, input int budget, output int dly, output logic [63:0] data);
    dly  = -1;
    data = '0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (lane == 0 ? nic1_rx_valid_out : nic0_rx_valid_out) begin
        dly  = k;
        data = (lane == 0) ? nic1_rx_out : nic0_rx_out;
        break;
      end
    end
  endtask

  typedef struct {
    int          lane;
    int          lat;
    logic [63:0] data;
    int          exp_dly;
  } lat_vec_t;

  lat_vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dly;
    int          n;
    int          peak;
    int          seen;
    logic [63:0] got;
    int          ev_rel [4];
    logic [63:0] ev_dat [4];

    tbl[0] = '{0, 1,   64'hA5A5_A5A5_A5A5_A5A5, 1};
    tbl[1] = '{1, 0,   64'h0123_4567_89AB_CDEF, 1};
    tbl[2] = '{1, 2,   64'hDEAD_BEEF_0000_0002, 2};
    tbl[3] = '{0, 7,   64'hCAFE_F00D_0000_0007, 7};
    tbl[4] = '{1, 100, 64'h1111_2222_3333_4444, 100};
    tbl[5] = '{0, 255, 64'hFFFF_0000_FFFF_0000, 255};

    reset = 1'b1;
    cfg_latency = LAT_W'(1);
    nic0_tx_in = '0; nic1_tx_in = '0;
    nic0_tx_valid_in = 1'b0; nic1_tx_valid_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_rx1_data", 64'(nic1_rx_out), 64'h0);
    chk("reset_occ_0to1", 64'(occupancy_0to1), 64'h0);
    chk("reset_drop_1to0", 64'(drop_cnt_1to0), 64'h0);

    // Latency table: one packet into an empty lane arrives exactly L edges later.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      idle(8);
      cfg_latency = LAT_W'(tbl[i].lat);
      send(tbl[i].lane, tbl[i].data);
      wait_rx(tbl[i].lane, tbl[i].exp_dly + 20, dly, got);
      chk("lat_delay", 64'(dly), 64'(tbl[i].exp_dly));
      chk("lat_data", got, tbl[i].data);
    end

    // Back-to-back burst of 8 on NIC_1, L=100.
    do_reset();
    idle(19);
    cfg_latency = LAT_W'(100);
    nic1_tx_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nic1_tx_in = 64'(i);
      tick();
    end
    nic1_tx_valid_in = 1'b0;
    n = 0;
    for (int rel = 8; rel <= 140; rel++) begin
      tick();
      if (nic0_rx_valid_out) begin
        chk("b2b_edge", 64'(rel), 64'(100 + n));
        chk("b2b_data", 64'(nic0_rx_out), 64'(n));
        n++;
      end
    end
    chk("b2b_count", 64'(n), 64'd8);

    // Overflow: 20 packets into a 16-deep lane with a long latency.
    do_reset();
    cfg_latency = LAT_W'(200);
    peak = 0;
    nic0_tx_valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nic0_tx_in = 64'(i);
      tick();
      if (int'(occupancy_0to1) > peak) peak = int'(occupancy_0to1);
    end
    nic0_tx_valid_in = 1'b0;
    chk("ovf_drops", 64'(drop_cnt_0to1), 64'd4);
    chk("ovf_peak", 64'(peak), 64'(DEPTH));
    n = 0;
    for (int k = 0; k < 250; k++) begin
      tick();
      if (nic1_rx_valid_out) begin
        chk("ovf_order", 64'(nic1_rx_out), 64'(n));
        n++;
      end
    end
    chk("ovf_delivered", 64'(n), 64'(DEPTH));

    // Latency decrease: P1 must wait behind P0.
    do_reset();
    cfg_latency = LAT_W'(50);
    send(0, 64'hAAAA_0000_0000_0000);
    cfg_latency = LAT_W'(5);
    send(0, 64'hBBBB_0000_0000_0001);
    n = 0;
    for (int rel = 2; rel <= 70; rel++) begin
      tick();
      if (nic1_rx_valid_out && n < 4) begin
        ev_rel[n] = rel;
        ev_dat[n] = nic1_rx_out;
        n++;
      end
    end
    chk("dec_count", 64'(n), 64'd2);
    if (n >= 2) begin
      chk("dec_p0_edge", 64'(ev_rel[0]), 64'd50);
      chk("dec_p0_data", ev_dat[0], 64'hAAAA_0000_0000_0000);
      chk("dec_p1_edge", 64'(ev_rel[1]), 64'd51);
      chk("dec_p1_data", ev_dat[1], 64'hBBBB_0000_0000_0001);
    end

    // Reset mid-flight discards queued packets.
    do_reset();
    cfg_latency = LAT_W'(30);
    send(0, 64'h1);
    send(0, 64'h2);
    send(0, 64'h3);
    idle(7);
    do_reset();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (nic1_rx_valid_out) seen++;
    end
    chk("rstmf_outputs", 64'(seen), 64'd0);
    chk("rstmf_occ", 64'(occupancy_0to1), 64'd0);
    chk("rstmf_drop", 64'(drop_cnt_0to1), 64'd0);
    chk("rstmf_data", 64'(nic1_rx_out), 64'd0);
    send(0, 64'h5555_6666_7777_8888);
    wait_rx(0, 60, dly, got);
    chk("rstmf_fresh_delay", 64'(dly), 64'd30);
    chk("rstmf_fresh_data", got, 64'h5555_6666_7777_8888);

    // Timestamp wrap: enqueue 10 counts before the counter wraps.
    do_reset();
    idle((1 << TS_W) - 10);
    cfg_latency = LAT_W'(20);
    send(1, 64'h7777_0000_0000_7777);
    wait_rx(1, 60, dly, got);
    chk("wrap_delay", 64'(dly), 64'd20);
    chk("wrap_data", got, 64'h7777_0000_0000_7777);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) cfg_latency = LAT_W'($urandom_range(0, 60));
      nic0_tx_valid_in = ($urandom_range(0, 3) != 0);
      nic1_tx_valid_in = ($urandom_range(0, 3) != 0);
      nic0_tx_in = {$urandom, $urandom};
      nic1_tx_in = {$urandom, $urandom};
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    nic0_tx_valid_in = 1'b0;
    nic1_tx_valid_in = 1'b0;
    idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
